set_bit_iterator: RTL and testbench
===================================

Name: set_bit_iterator

Overview:
- Streaming stage that accepts a DATA_WIDTH-bit word and emits the index of each set bit, one per handshake, LSB first.
- Each index is the trailing-zero count of the remaining word. After each index is taken, the lowest set bit is cleared.
- Sits downstream of the team's combinational trailing-zero counter and turns it into a sequenced valid/ready index stream for request/grant and scatter logic.

Parameters:
- DATA_WIDTH, 32, width of input word; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_WIDTH  word to iterate.
- out_valid  output  1  out_idx/out_pos/out_last valid.
- out_ready  input  1  downstream accepts current index.
- out_idx  output  $clog2(DATA_WIDTH)  bit position of lowest remaining set bit.
- out_pos  output  $clog2(DATA_WIDTH)  ordinal of this index within the current word (0 = first).
- out_last  output  1  this is the final set bit of the word.
- zero_word  output  1  one-cycle pulse: an all-zero word was accepted.

Behaviour:
- Reset: asynchronous on resetn low. Returns to IDLE; word register, out_pos counter and zero_word clear to 0. While in reset, out_valid=0 and in_ready=0. in_ready=1 in the first cycle after release.
- States: IDLE, ITER.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept on in_valid&&in_ready.
  - in_data!=0: load word register, clear out_pos, go to ITER.
  - in_data==0: stay in IDLE; zero_word=1 in the next cycle only; nothing emitted.
- ITER:
  - out_valid=1.
  - out_idx = trailing-zero count of word register (combinational from register).
  - out_last = ((word & (word-1)) == 0).
  - out_pos = counter value.
- Output handshake (out_valid&&out_ready):
  - word <= word & (word-1); out_pos <= out_pos+1.
  - If out_last, go to IDLE.
- Backpressure: while out_ready=0, out_idx/out_pos/out_last are held stable and out_valid stays 1. out_valid never drops without a handshake except on reset.
- Back-to-back:
  - in_ready = IDLE || (ITER && out_valid && out_ready && out_last). This is a combinational path from out_ready by design.
  - A word accepted on the last-index handshake follows the IDLE accept rules: a nonzero word loads and ITER continues; a zero word goes to IDLE and pulses zero_word. No bubble.
- Latency: word accepted at edge N gives first out_valid=1 in cycle N+1. Throughput is one index per cycle with out_ready held high.
- Widths:
  - out_pos max value is DATA_WIDTH-1 (all-ones word), so no overflow.
  - word-1 is computed only when word!=0, which always holds in ITER.
- Reset mid-ITER: the word is dropped; no partial completion is signalled.
- in_data is sampled only on an accept; changes at other times are ignored.

Decomposition:
- Shared package set_bit_iterator_pkg:
  - localparams IDX_W = $clog2(DATA_WIDTH).
  - State enum typedef iter_state_e {IDLE, ITER}.
- One sub-module, lsb_index: combinational trailing-zero count of a DATA_WIDTH word truncated to IDX_W bits. Instantiated once on the word register.
- State register, word register, out_pos counter and zero_word flop all live in the top module.

Test Plan:
1. in_data=0x0000_0028, out_ready=1: cycle+1 idx=3 pos=0 last=0; cycle+2 idx=5 pos=1 last=1; cycle+3 in_ready=1, out_valid=0.
2. in_data=0x0000_0000 accepted: zero_word=1 for exactly one cycle; out_valid stays 0; in_ready stays 1.
3. in_data=0x8000_0001 with out_ready=0 for 3 cycles: idx=0 pos=0 held stable all 3 cycles. Then out_ready=1: idx=0, then idx=31 with last=1.
4. in_data=0xFFFF_FFFF, out_ready=1: 32 consecutive outputs, idx=pos=0..31, last only on idx 31; no gaps.
5. Back-to-back: 0x0000_0004 then 0x0000_0300 presented with in_valid held. Second word is accepted on the idx=2 last handshake; next cycle gives idx=8 pos=0, then idx=9 last=1.
6. resetn pulsed low during 0x0000_00F0 after idx=4 is consumed: out_valid=0 immediately (asynchronous). After release, in_ready=1 and no stale indices appear.

Source files
------------

// File: rtl/set_bit_iterator_pkg.sv
// ============================================================
// Module   : set_bit_iterator_pkg
// Brief    : Shared widths and state encoding for set_bit_iterator
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

package set_bit_iterator_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int IDX_W          = $clog2(DEF_DATA_WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ITER = 1'b1
  } iter_state_e;

endpackage

`default_nettype wire

// File: rtl/set_bit_iterator_if.sv
// ============================================================
// Module   : set_bit_iterator_if
// Brief    : Word-in / index-out handshake bundle for set_bit_iterator
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

interface set_bit_iterator_if #(
  parameter int DATA_WIDTH = 32
);
  import set_bit_iterator_pkg::*;

  localparam int c_idx_w = $clog2(DATA_WIDTH);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [c_idx_w-1:0]    out_idx;
  logic [c_idx_w-1:0]    out_pos;
  logic                  out_last;
  logic                  zero_word;

  // The iterator itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_pos, out_last, zero_word
  );

  // Whoever feeds words and consumes indices
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_pos, out_last, zero_word
  );

endinterface

`default_nettype wire

// File: rtl/set_bit_iterator_lsb_index.sv
// ============================================================
// Module   : lsb_index
// Brief    : Combinational trailing-zero count of a word (0 for an all-zero word)
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module lsb_index #(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic [DATA_WIDTH-1:0]         word,
  output      logic [$clog2(DATA_WIDTH)-1:0] idx
);
  import set_bit_iterator_pkg::*;

  localparam int c_idx_w = $clog2(DATA_WIDTH);

  // Scan MSB down so the lowest set bit is the final writer
  always_comb begin
    idx = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (word[i]) begin
        idx = c_idx_w'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/set_bit_iterator.sv
// ============================================================
// Module   : set_bit_iterator
// Brief    : Emits the index of each set bit of an accepted word, LSB first
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module set_bit_iterator #(
  parameter int DATA_WIDTH = 32
) (
  input  wire logic     clk,
  input  wire logic     resetn,
  set_bit_iterator_if.slave bus
);
  import set_bit_iterator_pkg::*;

  localparam int c_idx_w = $clog2(DATA_WIDTH);

  iter_state_e           r_state;
  logic [DATA_WIDTH-1:0] r_word;
  logic [c_idx_w-1:0]    r_pos;
  logic                  r_zero_word;

  logic [c_idx_w-1:0]    w_idx;
  logic                  w_out_valid;
  logic                  w_last;
  logic                  w_out_hs;
  logic                  w_in_ready;
  logic                  w_in_hs;
  logic                  w_in_zero;

  lsb_index #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lsb_index (
    .word (r_word),
    .idx  (w_idx)
  );

  assign w_out_valid = (r_state == ITER);
  assign w_last      = ((r_word & (r_word - DATA_WIDTH'(1))) == '0);
  assign w_out_hs    = w_out_valid & bus.out_ready;

  // Refill on the final handshake keeps the stream bubble-free
  assign w_in_ready  = resetn & ((r_state == IDLE) | (w_out_hs & w_last));
  assign w_in_hs     = bus.in_valid & w_in_ready;
  assign w_in_zero   = (bus.in_data == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_pos       <= '0;
      r_zero_word <= 1'b0;
    end else begin
      r_zero_word <= w_in_hs & w_in_zero;
      if (w_in_hs) begin
        r_pos <= '0;
        if (w_in_zero) begin
          r_state <= IDLE;
          r_word  <= '0;
        end else begin
          r_state <= ITER;
          r_word  <= bus.in_data;
        end
      end else if (w_out_hs) begin
        r_word <= r_word & (r_word - DATA_WIDTH'(1));
        r_pos  <= r_pos + c_idx_w'(1);
        if (w_last) begin
          r_state <= IDLE;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_idx   = w_idx;
  assign bus.out_pos   = r_pos;
  assign bus.out_last  = w_out_valid & w_last;
  assign bus.zero_word = r_zero_word;

endmodule

`default_nettype wire

// File: tb/tb_set_bit_iterator.sv
// ============================================================
// Module   : tb_set_bit_iterator
// Brief    : Self-checking bench for set_bit_iterator
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module tb_set_bit_iterator;

  localparam int DW = 32;

  logic clk;
  logic resetn;

  set_bit_iterator_if #(.DATA_WIDTH(DW)) bus ();

  set_bit_iterator #(.DATA_WIDTH(DW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            count;
    int            first_idx;
    int            last_idx;
  } vec_t;

  typedef struct {
    int idx;
    int pos;
    bit last;
  } ent_t;

  vec_t vecs [6];
  ent_t q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  // Apply one word with out_ready high and summarise what comes out
  task automatic run_vec(input vec_t v);
    int n = 0;
    int first = -1;
    int lasti = -1;
    bit done = 0;
    bus.in_valid  = 1'b1;
    bus.in_data   = v.data;
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    look();
    if (v.count == 0) begin
      chk("vec_zero_pulse", bus.zero_word, 1);
      chk("vec_zero_novalid", bus.out_valid, 0);
      cyc();
      look();
      chk("vec_zero_single", bus.zero_word, 0);
    end else begin
      for (int c = 0; c < 40 && !done; c++) begin
        if (bus.out_valid) begin
          if (n == 0) first = int'(bus.out_idx);
          chk("vec_pos", bus.out_pos, n);
          if (bus.out_last) begin
            lasti = int'(bus.out_idx);
            done  = 1;
          end
          n++;
        end
        cyc();
        look();
      end
      chk("vec_done", done, 1);
      chk("vec_count", n, v.count);
      chk("vec_first", first, v.first_idx);
      chk("vec_last", lasti, v.last_idx);
      chk("vec_idle_after", bus.out_valid, 0);
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    int            nb;
    int            p;
    bit            exp_valid;
    bit            exp_rdy;
    bit            zero_pend;

    vecs[0] = '{32'h0000_0001, 1, 0, 0};
    vecs[1] = '{32'h8000_0000, 1, 31, 31};
    vecs[2] = '{32'h0001_0100, 2, 8, 16};
    vecs[3] = '{32'h0000_0005, 2, 0, 2};
    vecs[4] = '{32'hF000_000F, 8, 0, 31};
    vecs[5] = '{32'h0000_0000, 0, 0, 0};

    resetn        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_zero_word", bus.zero_word, 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    look();
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_out_valid", bus.out_valid, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Two set bits, free-flowing downstream
    bus.in_valid = 1'b1; bus.in_data = 32'h0000_0028; bus.out_ready = 1'b1;
    cyc(); bus.in_valid = 1'b0; look();
    chk("t1_valid0", bus.out_valid, 1);
    chk("t1_idx0", bus.out_idx, 3);
    chk("t1_pos0", bus.out_pos, 0);
    chk("t1_last0", bus.out_last, 0);
    cyc(); look();
    chk("t1_idx1", bus.out_idx, 5);
    chk("t1_pos1", bus.out_pos, 1);
    chk("t1_last1", bus.out_last, 1);
    cyc(); look();
    chk("t1_idle_valid", bus.out_valid, 0);
    chk("t1_idle_ready", bus.in_ready, 1);

    // All-zero word
    bus.in_valid = 1'b1; bus.in_data = 32'h0;
    cyc(); bus.in_valid = 1'b0; look();
    chk("t2_pulse", bus.zero_word, 1);
    chk("t2_novalid", bus.out_valid, 0);
    chk("t2_ready", bus.in_ready, 1);
    cyc(); look();
    chk("t2_pulse_end", bus.zero_word, 0);
    chk("t2_novalid2", bus.out_valid, 0);

    // Backpressure hold
    bus.in_valid = 1'b1; bus.in_data = 32'h8000_0001; bus.out_ready = 1'b0;
    cyc(); bus.in_valid = 1'b0; bus.in_data = 32'hFFFF_FFFF; look();
    for (int c = 0; c < 3; c++) begin
      chk("t3_hold_valid", bus.out_valid, 1);
      chk("t3_hold_idx", bus.out_idx, 0);
      chk("t3_hold_pos", bus.out_pos, 0);
      chk("t3_hold_last", bus.out_last, 0);
      chk("t3_hold_ready", bus.in_ready, 0);
      cyc(); look();
    end
    bus.out_ready = 1'b1; look();
    chk("t3_rel_idx", bus.out_idx, 0);
    cyc(); look();
    chk("t3_idx31", bus.out_idx, 31);
    chk("t3_pos1", bus.out_pos, 1);
    chk("t3_last", bus.out_last, 1);
    cyc(); look();
    chk("t3_done", bus.out_valid, 0);

    // All-ones word: 32 back-to-back indices
    bus.in_valid = 1'b1; bus.in_data = 32'hFFFF_FFFF;
    cyc(); bus.in_valid = 1'b0; look();
    for (int i = 0; i < 32; i++) begin
      chk("t4_valid", bus.out_valid, 1);
      chk("t4_idx", bus.out_idx, i);
      chk("t4_pos", bus.out_pos, i);
      chk("t4_last", bus.out_last, (i == 31));
      cyc(); look();
    end
    chk("t4_done", bus.out_valid, 0);

    // Back-to-back words with in_valid held
    bus.in_valid = 1'b1; bus.in_data = 32'h0000_0004;
    cyc(); bus.in_data = 32'h0000_0300; look();
    chk("t5_idx2", bus.out_idx, 2);
    chk("t5_last2", bus.out_last, 1);
    chk("t5_ready", bus.in_ready, 1);
    cyc(); bus.in_valid = 1'b0; look();
    chk("t5_valid8", bus.out_valid, 1);
    chk("t5_idx8", bus.out_idx, 8);
    chk("t5_pos8", bus.out_pos, 0);
    chk("t5_last8", bus.out_last, 0);
    cyc(); look();
    chk("t5_idx9", bus.out_idx, 9);
    chk("t5_pos9", bus.out_pos, 1);
    chk("t5_last9", bus.out_last, 1);
    cyc(); look();
    chk("t5_done", bus.out_valid, 0);

    // Reset in the middle of a word
    bus.in_valid = 1'b1; bus.in_data = 32'h0000_00F0;
    cyc(); bus.in_valid = 1'b0; look();
    chk("t6_idx4", bus.out_idx, 4);
    cyc(); look();
    chk("t6_idx5", bus.out_idx, 5);
    resetn = 1'b0; look();
    chk("t6_async_valid", bus.out_valid, 0);
    chk("t6_async_ready", bus.in_ready, 0);
    cyc(); cyc();
    resetn = 1'b1; look();
    chk("t6_rel_ready", bus.in_ready, 1);
    chk("t6_rel_valid", bus.out_valid, 0);
    for (int c = 0; c < 3; c++) begin
      cyc(); look();
      chk("t6_no_stale", bus.out_valid, 0);
    end

    // Random traffic against a queue of expected indices
    bus.in_valid = 1'b0;
    cyc(); cyc();
    zero_pend = 0;
    q.delete();
    for (int t = 0; t < 3000; t++) begin
      case ($urandom_range(0, 7))
        0:       d = '0;
        1:       d = '1;
        2:       d = 32'h1 << $urandom_range(0, 31);
        default: d = $urandom & $urandom;
      endcase
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_data   = d;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      look();
      exp_valid = (q.size() > 0);
      chk("rnd_out_valid", bus.out_valid, exp_valid);
      if (exp_valid) begin
        chk("rnd_idx", bus.out_idx, q[0].idx);
        chk("rnd_pos", bus.out_pos, q[0].pos);
        chk("rnd_last", bus.out_last, q[0].last);
      end
      exp_rdy = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
      chk("rnd_in_ready", bus.in_ready, exp_rdy);
      chk("rnd_zero_word", bus.zero_word, zero_pend);
      if (exp_valid && bus.out_ready) void'(q.pop_front());
      zero_pend = bus.in_valid && exp_rdy && (d == '0);
      if (bus.in_valid && exp_rdy && d != '0) begin
        nb = 0;
        for (int b = 0; b < DW; b++) if (d[b]) nb++;
        p = 0;
        for (int b = 0; b < DW; b++) begin
          if (d[b]) begin
            q.push_back('{b, p, (p == nb - 1)});
            p++;
          end
        end
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
